// File: rtl/dualmem_ctrl_defs.sv
// Shared definitions for the dualmem port controller.
// Holds the FSM state encoding, the beats per word and the requester ids.
package dualmem_ctrl_defs;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam int BEATS = 4;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_DBG  = 1'b1;

endpackage

// File: rtl/dualmem_port_ctrl_rr_arb2.sv
// Two-way round-robin arbiter with a registered priority pointer.
// The grant is combinational; the pointer moves to the other requester after any grant.
module rr_arb2
    import dualmem_ctrl_defs::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        // NOTE: give every combinational output a value before any branch so no latch is inferred.
        gnt = 2'b00;
        if (en && !rst) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (ptr == REQ_DBG) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= REQ_CORE;
        end else if (gnt[0]) begin
            ptr <= REQ_DBG;
        end else if (gnt[1]) begin
            ptr <= REQ_CORE;
        end
    end

endmodule

// File: rtl/dualmem_port_ctrl.sv
// Word-access controller for one byte-wide dualmem port, shared round-robin by two requesters.
// Each 32-bit word is sequenced as four byte beats; reads are reassembled before the response.
module dualmem_port_ctrl
    import dualmem_ctrl_defs::*;
#(
    parameter int RWIDTH = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [RWIDTH-3:0] addr0,
    input  logic [RWIDTH-3:0] addr1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    input  logic [3:0]        be0,
    input  logic [3:0]        be1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [RWIDTH-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    state_t            state;
    logic [1:0]        beat;
    logic              lat_id;
    logic              lat_we;
    logic [RWIDTH-3:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic [3:0]        lat_be;
    logic [23:0]       asm_q;
    logic [31:0]       rdata_q;
    logic [1:0]        rvalid_q;
    logic [1:0]        gnt;
    logic              in_access;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({req1, req0}),
        .en  (state == IDLE),
        .gnt (gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            beat      <= 2'd0;
            lat_id    <= REQ_CORE;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            asm_q     <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 2'b00;
        end else begin
            rvalid_q <= 2'b00;
            case (state)
                IDLE: begin
                    if (gnt != 2'b00) begin
                        lat_id    <= gnt[1] ? REQ_DBG : REQ_CORE;
                        lat_we    <= gnt[1] ? we1 : we0;
                        lat_addr  <= gnt[1] ? addr1 : addr0;
                        lat_wdata <= gnt[1] ? wdata1 : wdata0;
                        lat_be    <= gnt[1] ? be1 : be0;
                        beat      <= 2'd0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Read data lags the address by one cycle, so beat k stores byte k-1.
                    if (!lat_we) begin
                        case (beat)
                            2'd1:    asm_q[7:0]   <= mem_rdata;
                            2'd2:    asm_q[15:8]  <= mem_rdata;
                            2'd3:    asm_q[23:16] <= mem_rdata;
                            default: ;
                        endcase
                    end
                    beat <= beat + 2'd1;
                    if (beat == 2'(BEATS - 1)) begin
                        state <= lat_we ? IDLE : CAPTURE;
                    end
                end
                CAPTURE: begin
                    rdata_q          <= {mem_rdata, asm_q};
                    rvalid_q[lat_id] <= 1'b1;
                    state            <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs are forced low while reset is held, before the state registers clear.
    assign in_access = (state == ACCESS) && !rst;

    assign gnt0      = gnt[0];
    assign gnt1      = gnt[1];
    assign rvalid0   = rvalid_q[0] && !rst;
    assign rvalid1   = rvalid_q[1] && !rst;
    assign rdata     = rst ? 32'd0 : rdata_q;
    assign busy      = (state != IDLE) && !rst;

    assign mem_en    = in_access && (lat_we ? lat_be[beat] : 1'b1);
    assign mem_we    = in_access && lat_we && lat_be[beat];
    assign mem_addr  = in_access ? {lat_addr, beat} : '0;
    assign mem_wdata = in_access ? lat_wdata[{beat, 3'b000} +: 8] : 8'd0;

endmodule
